reg_wb_ctrl: RTL and testbench

- Write-back controller: the producer side of the 32x32 register file's single write port.
- Accepts results from two sources, the ALU and the load path, through valid/ready handshakes.
- Buffers results in a small in-order queue and drains one write per clock onto the register-file write port (write enable, address, data).
- Provides a bypass lookup so operand fetch can see results that are still pending.

---
 rtl/reg_wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/reg_wb_ctrl.sv | 116 +++++++++++
 tb/tb_reg_wb_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file write-back controller:
// default widths, the hard-wired zero register and the pending-entry record.
package reg_wb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0]        rd;
      logic signed [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes: up to two pushes and
// one pop per clock, synchronous flush, and an age-ordered view of its contents.
module wb_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    flush_i,
   input  logic                    push0Valid_i,
   input  logic [ADDR_W-1:0]       push0Rd_i,
   input  logic [DATA_W-1:0]       push0Data_i,
   input  logic                    push1Valid_i,
   input  logic [ADDR_W-1:0]       push1Rd_i,
   input  logic [DATA_W-1:0]       push1Data_i,
   input  logic                    pop_i,
   output logic [ADDR_W-1:0]       headRd_o,
   output logic [DATA_W-1:0]       headData_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    ageValid_o [DEPTH],
   output logic [ADDR_W-1:0]       ageRd_o    [DEPTH],
   output logic [DATA_W-1:0]       ageData_o  [DEPTH]
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0]     rdPtr_q, rdPtr_d;
   logic [PW-1:0]     wrPtr_q, wrPtr_d;
   logic [PW-1:0]     wrPtrNext;
   logic [CW-1:0]     count_q, count_d;
   logic [1:0]        nPush;
   logic [ADDR_W-1:0] rdMem_q   [DEPTH];
   logic [DATA_W-1:0] dataMem_q [DEPTH];

   // Pointers wrap for free because DEPTH is a power of two; flush overrides everything.
   always_comb begin
      nPush     = 2'(push0Valid_i) + 2'(push1Valid_i);
      wrPtrNext = wrPtr_q + PW'(1);
      rdPtr_d   = rdPtr_q + PW'(pop_i);
      wrPtr_d   = wrPtr_q + PW'(nPush);
      count_d   = count_q + CW'(nPush) - CW'(pop_i);
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Slot 0 is the older of two same-cycle pushes; storage needs no reset.
   always_ff @(posedge clk_i) begin
      if (!flush_i) begin
         if (push0Valid_i) begin
            rdMem_q[wrPtr_q]   <= push0Rd_i;
            dataMem_q[wrPtr_q] <= push0Data_i;
         end
         if (push1Valid_i) begin
            rdMem_q[wrPtrNext]   <= push1Rd_i;
            dataMem_q[wrPtrNext] <= push1Data_i;
         end
      end
   end

   assign headRd_o   = rdMem_q[rdPtr_q];
   assign headData_o = dataMem_q[rdPtr_q];
   assign count_o    = count_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ageValid_o[i] = CW'(i) < count_q;
         ageRd_o[i]    = rdMem_q[rdPtr_q + PW'(i)];
         ageData_o[i]  = dataMem_q[rdPtr_q + PW'(i)];
      end
   end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller feeding the register-file write port from ALU and load
// sources. Define REG_WB_FWD_EN to build the bypass lookup; otherwise fwd_* read 0.
module reg_wb_ctrl #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = reg_wb_pkg::DATA_W,
   parameter int ADDR_W = reg_wb_pkg::ADDR_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alu_valid,
   input  logic [ADDR_W-1:0]       alu_rd,
   input  logic [DATA_W-1:0]       alu_data,
   output logic                    alu_ready,
   input  logic                    mem_valid,
   input  logic [ADDR_W-1:0]       mem_rd,
   input  logic [DATA_W-1:0]       mem_data,
   output logic                    mem_ready,
   input  logic                    flush,
   output logic                    wb_en,
   output logic [ADDR_W-1:0]       wb_addr,
   output logic [DATA_W-1:0]       wb_data,
   input  logic [ADDR_W-1:0]       fwd_addr,
   output logic                    fwd_hit,
   output logic [DATA_W-1:0]       fwd_data,
   output logic [$clog2(DEPTH):0]  pending
);

   import reg_wb_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]     fifoCount;
   logic [CW-1:0]     freeSlots;
   logic              queueEmpty;
   logic              memPush, aluPush;
   logic              push0Valid, push1Valid;
   logic [ADDR_W-1:0] push0Rd;
   logic [DATA_W-1:0] push0Data;
   logic [ADDR_W-1:0] headRd;
   logic [DATA_W-1:0] headData;
   logic              ageValid [DEPTH];
   logic [ADDR_W-1:0] ageRd    [DEPTH];
   logic [DATA_W-1:0] ageData  [DEPTH];

   // Readiness uses the registered occupancy only, so a pop never frees a slot early.
   assign freeSlots = CW'(DEPTH) - fifoCount;
   assign mem_ready = freeSlots >= CW'(1);
   assign alu_ready = (freeSlots >= CW'(2)) || ((freeSlots == CW'(1)) && !mem_valid);

   // A handshake to register 0, or one in a flush cycle, completes without queuing.
   assign memPush = mem_valid && mem_ready && (mem_rd != ADDR_W'(ZERO_REG)) && !flush;
   assign aluPush = alu_valid && alu_ready && (alu_rd != ADDR_W'(ZERO_REG)) && !flush;

   assign push0Valid = memPush || aluPush;
   assign push0Rd    = memPush ? mem_rd : alu_rd;
   assign push0Data  = memPush ? mem_data : alu_data;
   assign push1Valid = memPush && aluPush;

   wb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i        (clk),
      .reset_i      (reset),
      .flush_i      (flush),
      .push0Valid_i (push0Valid),
      .push0Rd_i    (push0Rd),
      .push0Data_i  (push0Data),
      .push1Valid_i (push1Valid),
      .push1Rd_i    (alu_rd),
      .push1Data_i  (alu_data),
      .pop_i        (wb_en),
      .headRd_o     (headRd),
      .headData_o   (headData),
      .count_o      (fifoCount),
      .ageValid_o   (ageValid),
      .ageRd_o      (ageRd),
      .ageData_o    (ageData)
   );

   assign queueEmpty = (fifoCount == '0);
   assign wb_en      = !queueEmpty;
   assign wb_addr    = queueEmpty ? '0 : headRd;
   assign wb_data    = queueEmpty ? '0 : headData;
   assign pending    = fifoCount;

`ifdef REG_WB_FWD_EN
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fwd_addr != ADDR_W'(ZERO_REG)) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ageValid[i] && (ageRd[i] == fwd_addr)) begin
               fwd_hit  = 1'b1;
               fwd_data = ageData[i];
            end
         end
      end
   end
`else
   logic unusedFwd;

   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;

   always_comb begin
      unusedFwd = ^fwd_addr;
      for (int i = 0; i < DEPTH; i++) begin
         unusedFwd = unusedFwd ^ ageValid[i] ^ (^ageRd[i]) ^ (^ageData[i]);
      end
   end
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the write-back rules.
module tb_reg_wb_ctrl;

   import reg_wb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        aluV, memV, flushV;
   logic [4:0]  aluRd, memRd, fwdA;
   logic [31:0] aluData, memData;
   logic        alu_ready, mem_ready, wb_en, fwd_hit;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, fwd_data;
   logic [2:0]  pending;

   int          compared   = 0;
   int          mismatched = 0;
   wb_entry_t   modelQ[$];
   logic        lastMemAcc = 1'b0;
   logic        lastAluAcc = 1'b0;

   always #5 clk = ~clk;

   reg_wb_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (aluV),
      .alu_rd    (aluRd),
      .alu_data  (aluData),
      .alu_ready (alu_ready),
      .mem_valid (memV),
      .mem_rd    (memRd),
      .mem_data  (memData),
      .mem_ready (mem_ready),
      .flush     (flushV),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .fwd_addr  (fwdA),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
      .pending   (pending)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check outputs against the model at the falling edge, then advance the model.
   task automatic applyStimulus();
      int          size;
      int          free;
      logic        expMemRdy, expAluRdy, expHit;
      logic [4:0]  expAddr;
      logic [31:0] expData, expFwd;
      @(negedge clk);
      size      = modelQ.size();
      free      = DEPTH - size;
      expMemRdy = (free >= 1);
      expAluRdy = (free >= 2) || ((free == 1) && !memV);
      expAddr   = (size != 0) ? modelQ[0].rd : 5'd0;
      expData   = (size != 0) ? modelQ[0].data : 32'd0;
      expHit    = 1'b0;
      expFwd    = 32'd0;
`ifdef REG_WB_FWD_EN
      if (fwdA != 5'd0) begin
         for (int i = size - 1; i >= 0; i--) begin
            if (modelQ[i].rd == fwdA) begin
               expHit = 1'b1;
               expFwd = modelQ[i].data;
               break;
            end
         end
      end
`endif
      checkOutput("mem_ready", mem_ready, expMemRdy);
      checkOutput("alu_ready", alu_ready, expAluRdy);
      checkOutput("wb_en", wb_en, size != 0);
      checkOutput("wb_addr", wb_addr, expAddr);
      checkOutput("wb_data", wb_data, expData);
      checkOutput("pending", pending, size);
      checkOutput("fwd_hit", fwd_hit, expHit);
      checkOutput("fwd_data", fwd_data, expFwd);
      lastMemAcc = memV && expMemRdy;
      lastAluAcc = aluV && expAluRdy;
      if (flushV) begin
         modelQ.delete();
      end else begin
         if (size != 0) void'(modelQ.pop_front());
         if (lastMemAcc && memRd != 5'd0) modelQ.push_back('{rd: memRd, data: memData});
         if (lastAluAcc && aluRd != 5'd0) modelQ.push_back('{rd: aluRd, data: aluData});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      aluV   = 1'b0;
      memV   = 1'b0;
      flushV = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      aluV    = 1'b0; aluRd = '0; aluData = '0;
      memV    = 1'b0; memRd = '0; memData = '0;
      flushV  = 1'b0;
      fwdA    = '0;

      #3;
      checkOutput("rst_wb_en", wb_en, 1'b0);
      checkOutput("rst_wb_addr", wb_addr, 5'd0);
      checkOutput("rst_wb_data", wb_data, 32'd0);
      checkOutput("rst_pending", pending, 3'd0);
      checkOutput("rst_fwd_hit", fwd_hit, 1'b0);
      checkOutput("rst_fwd_data", fwd_data, 32'd0);
      #10 reset = 1'b0;
      @(posedge clk); #1;

      // single ALU write
      aluV = 1'b1; aluRd = 5'd5; aluData = 32'd1234;
      applyStimulus();
      idleInputs();
      repeat (3) applyStimulus();

      // both sources into an empty queue
      memV = 1'b1; memRd = 5'd3; memData = -32'sd7;
      aluV = 1'b1; aluRd = 5'd4; aluData = 32'd99;
      applyStimulus();
      idleInputs();
      repeat (3) applyStimulus();

      // saturate both sources across pointer wrap
      for (int c = 0; c < 12; c++) begin
         if (c == 0 || lastMemAcc) begin
            memV = 1'b1; memRd = 5'($urandom_range(1, 7)); memData = $urandom;
         end
         if (c == 0 || lastAluAcc) begin
            aluV = 1'b1; aluRd = 5'($urandom_range(1, 7)); aluData = $urandom;
         end
         applyStimulus();
      end
      idleInputs();
      repeat (5) applyStimulus();

      // register 0 is dropped
      aluV = 1'b1; aluRd = 5'd0; aluData = 32'd555;
      applyStimulus();
      idleInputs();
      repeat (2) applyStimulus();

      // bypass picks the youngest r7
      memV = 1'b1; memRd = 5'd7; memData = 32'd10;
      aluV = 1'b1; aluRd = 5'd7; aluData = 32'd20;
      applyStimulus();
      idleInputs();
      fwdA = 5'd7;
      repeat (3) applyStimulus();

      // asynchronous reset with three entries pending
      memV = 1'b1; memRd = 5'd9; memData = 32'd1;
      aluV = 1'b1; aluRd = 5'd10; aluData = 32'd2;
      applyStimulus();
      memRd = 5'd11; memData = 32'd3;
      aluRd = 5'd12; aluData = 32'd4;
      applyStimulus();
      idleInputs();
      fwdA = 5'd11;
      checkOutput("pre_rst_pending", pending, 3'd3);
      reset = 1'b1;
      #1;
      checkOutput("async_wb_en", wb_en, 1'b0);
      checkOutput("async_wb_addr", wb_addr, 5'd0);
      checkOutput("async_wb_data", wb_data, 32'd0);
      checkOutput("async_pending", pending, 3'd0);
      checkOutput("async_fwd_hit", fwd_hit, 1'b0);
      modelQ.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      applyStimulus();

      // flush with two entries pending
      memV = 1'b1; memRd = 5'd13; memData = 32'd5;
      aluV = 1'b1; aluRd = 5'd14; aluData = 32'd6;
      applyStimulus();
      idleInputs();
      flushV = 1'b1;
      applyStimulus();
      flushV = 1'b0;
      applyStimulus();
      checkOutput("post_flush_pending", pending, 3'd0);

      // random traffic, producers hold while stalled
      for (int c = 0; c < 600; c++) begin
         if (!memV || lastMemAcc) begin
            memV = ($urandom_range(0, 9) < 7); memRd = 5'($urandom_range(0, 7)); memData = $urandom;
         end
         if (!aluV || lastAluAcc) begin
            aluV = ($urandom_range(0, 9) < 7); aluRd = 5'($urandom_range(0, 7)); aluData = $urandom;
         end
         flushV = ($urandom_range(0, 29) == 0);
         fwdA   = 5'($urandom_range(0, 7));
         applyStimulus();
      end
      idleInputs();
      repeat (6) applyStimulus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
